// File: rtl/pc_pkg.sv
// Shared types and constants for the PC fetch sequencer slice.
package pc_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetchState_e;

    localparam int          INSTR_BYTES         = 4;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;
    localparam logic [31:0] WORD_ALIGN_MASK     = 32'hFFFF_FFFC;

    // Clears the byte-offset bits so a redirect always lands on an instruction boundary.
    function automatic logic [31:0] alignAddr(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_incr.sv
// PC+4 incrementer; the sum wraps modulo 2^32 so the last word rolls over to zero.
module pc_incr
    import pc_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic [31:0] pcPlus4_o
);

    assign pcPlus4_o = pc_i + 32'(INSTR_BYTES);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Optional build macro PC_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR
// and pulse misalignTrap; without it the low address bits are silently cleared.
module pc_fetch_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    output logic        instrValid,
    output logic [31:0] instrData,
    output logic [31:0] instrPC,
    input  logic        instrReady,
    output logic        misalignTrap
);

    fetchState_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic        instrValid_q, instrValid_d;
    logic [31:0] instrData_q, instrData_d;
    logic [31:0] instrPC_q, instrPC_d;
    logic [31:0] pcPlus4;
    logic [31:0] redirectAddr;
    logic        reqFire;

    pc_incr uIncr (
        .pc_i      (pc_q),
        .pcPlus4_o (pcPlus4)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_q, trap_d;

    assign misaligned   = (redirectTarget[1:0] != 2'b00);
    assign redirectAddr = misaligned ? TRAP_VECTOR : alignAddr(redirectTarget);
    assign trap_d       = redirectValid && misaligned;
    assign misalignTrap = trap_q;

    // One-cycle trap pulse registered from the redirect that caused it.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
`else
    logic unusedTrapVector;

    assign unusedTrapVector = ^TRAP_VECTOR;
    assign redirectAddr     = alignAddr(redirectTarget);
    assign misalignTrap     = 1'b0;
`endif

    // Request is gated by reset so nothing is issued while reset is held.
    assign imemReq    = resetN && (state_q == REQ) && !stall;
    assign imemAddr   = pc_q;
    assign reqFire    = imemReq && imemGnt;
    assign instrValid = instrValid_q;
    assign instrData  = instrData_q;
    assign instrPC    = instrPC_q;

    // Next-state logic; a redirect outranks every other event in every state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        instrValid_d = instrValid_q;
        instrData_d  = instrData_q;
        instrPC_d    = instrPC_q;

        case (state_q)
            REQ: begin
                if (redirectValid) begin
                    pc_d = redirectAddr;
                    if (reqFire) begin
                        squash_d = 1'b1;
                        state_d  = WAIT;
                    end
                end else if (reqFire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirectValid) begin
                    pc_d = redirectAddr;
                    if (imemRspValid) begin
                        squash_d = 1'b0;
                        state_d  = REQ;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (imemRspValid) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = REQ;
                    end else begin
                        instrData_d  = imemRspData;
                        instrPC_d    = pc_q;
                        pc_d         = pcPlus4;
                        instrValid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirectValid) begin
                    instrValid_d = 1'b0;
                    pc_d         = redirectAddr;
                    state_d      = REQ;
                end else if (instrReady) begin
                    instrValid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // State, PC and held-instruction registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            squash_q     <= 1'b0;
            instrValid_q <= 1'b0;
            instrData_q  <= 32'h0;
            instrPC_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            squash_q     <= squash_d;
            instrValid_q <= instrValid_d;
            instrData_q  <= instrData_d;
            instrPC_q    <= instrPC_d;
        end
    end

endmodule
